// File: rtl/sw_debounce_event.sv
// rtl/sw_debounce_event.sv - per-channel switch debounce with edge pulses and change-event handshake
module sw_debounce_event #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SYNC_IN,
  output logic [WIDTH-1:0] STABLE,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             EVT_VALID,
  output logic [WIDTH-1:0] EVT_DATA,
  output logic [WIDTH-1:0] EVT_CHANGED,
  input  logic             EVT_ACK
);

  // Count value reached on the last disagreeing sample before a new level is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_data_q, evt_data_d;
  logic [WIDTH-1:0] evt_changed_q, evt_changed_d;

  // Per-channel disagreement counters; a channel flips after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    stable_d = stable_q;
    flip     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (SYNC_IN[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]    = '0;
        stable_d[i] = SYNC_IN[i];
        flip[i]     = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    rise_d = flip & stable_d;
    fall_d = flip & ~stable_d;
  end

  // Event record: load on first change, coalesce while pending, retire on ack (a same-edge flip starts a fresh event).
  always_comb begin
    evt_valid_d   = evt_valid_q;
    evt_data_d    = evt_data_q;
    evt_changed_d = evt_changed_q;
    if (flip != '0) begin
      evt_valid_d = 1'b1;
      evt_data_d  = stable_d;
      if (evt_valid_q && !EVT_ACK) begin
        evt_changed_d = evt_changed_q | flip;
      end else begin
        evt_changed_d = flip;
      end
    end else if (evt_valid_q && EVT_ACK) begin
      evt_valid_d   = 1'b0;
      evt_changed_d = '0;
    end
  end

  // State registers with synchronous reset that also discards partial counts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q      <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      evt_valid_q   <= 1'b0;
      evt_data_q    <= '0;
      evt_changed_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q      <= stable_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      evt_valid_q   <= evt_valid_d;
      evt_data_q    <= evt_data_d;
      evt_changed_q <= evt_changed_d;
    end
  end

  assign STABLE      = stable_q;
  assign RISE        = rise_q;
  assign FALL        = fall_q;
  assign EVT_VALID   = evt_valid_q;
  assign EVT_DATA    = evt_data_q;
  assign EVT_CHANGED = evt_changed_q;

endmodule

// File: tb/tb_sw_debounce_event.sv
// tb/tb_sw_debounce_event.sv - vector table, corner sequences and randomized model check for sw_debounce_event
module tb_sw_debounce_event;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] SYNC_IN = '0;
  logic         EVT_ACK = 1'b0;
  logic [W-1:0] STABLE, RISE, FALL, EVT_DATA, EVT_CHANGED;
  logic         EVT_VALID;

  int total = 0;
  int bad   = 0;

  sw_debounce_event #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .SYNC_IN(SYNC_IN), .STABLE(STABLE), .RISE(RISE), .FALL(FALL),
    .EVT_VALID(EVT_VALID), .EVT_DATA(EVT_DATA), .EVT_CHANGED(EVT_CHANGED), .EVT_ACK(EVT_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         rst;
    logic [W-1:0] sync;
    logic         ack;
    logic [W-1:0] stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         valid;
    logic [W-1:0] data;
    logic [W-1:0] changed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [W-1:0] s, input logic a, input logic [W-1:0] st,
                     input logic [W-1:0] ri, input logic [W-1:0] fa, input logic v,
                     input logic [W-1:0] da, input logic [W-1:0] ch);
    vec_t t;
    t.rst = r; t.sync = s; t.ack = a; t.stable = st; t.rise = ri; t.fall = fa;
    t.valid = v; t.data = da; t.changed = ch;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] s, input logic a);
    RST = r; SYNC_IN = s; EVT_ACK = a;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] st, input logic [W-1:0] ri,
                         input logic [W-1:0] fa, input logic v, input logic [W-1:0] da,
                         input logic [W-1:0] ch);
    chk({tag, ".stable"}, STABLE, st);
    chk({tag, ".rise"}, RISE, ri);
    chk({tag, ".fall"}, FALL, fa);
    chk({tag, ".valid"}, {7'd0, EVT_VALID}, {7'd0, v});
    chk({tag, ".data"}, EVT_DATA, da);
    chk({tag, ".changed"}, EVT_CHANGED, ch);
  endtask

  // Reference model: a level is accepted once the last D samples since reset all disagree with it.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_rise, m_fall, m_data, m_changed;
  logic         m_valid;

  task automatic model_edge(input logic r, input logic [W-1:0] s, input logic a);
    logic [W-1:0] f;
    logic [W-1:0] nst;
    if (r) begin
      hist.delete();
      m_stable = '0; m_rise = '0; m_fall = '0; m_valid = 1'b0; m_data = '0; m_changed = '0;
      return;
    end
    hist.push_back(s);
    if (hist.size() > D) void'(hist.pop_front());
    f = '0;
    if (hist.size() == D) begin
      f = '1;
      foreach (hist[k]) f = f & (hist[k] ^ m_stable);
    end
    nst = m_stable ^ f;
    m_rise = f & nst;
    m_fall = f & ~nst;
    m_stable = nst;
    if (f != 0) begin
      m_changed = (m_valid && !a) ? (m_changed | f) : f;
      m_valid = 1'b1;
      m_data = nst;
    end else if (m_valid && a) begin
      m_valid = 1'b0;
      m_changed = '0;
    end
  endtask

  initial begin
    // Reset, bit0 held high, accepted on 4th edge, then acked.
    add(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h01, 0, 8'h01, 8'h01, 8'h00, 1, 8'h01, 8'h01);
    add(0, 8'h01, 0, 8'h01, 8'h00, 8'h00, 1, 8'h01, 8'h01);
    add(0, 8'h01, 1, 8'h01, 8'h00, 8'h00, 0, 8'h01, 8'h00);
    add(0, 8'h01, 1, 8'h01, 8'h00, 8'h00, 0, 8'h01, 8'h00);
    // Coalesce bit2 then bit3, then ack coinciding with a bit4 flip, then plain ack.
    add(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h04, 0, 8'h04, 8'h04, 8'h00, 1, 8'h04, 8'h04);
    add(0, 8'h0C, 0, 8'h04, 8'h00, 8'h00, 1, 8'h04, 8'h04);
    add(0, 8'h0C, 0, 8'h04, 8'h00, 8'h00, 1, 8'h04, 8'h04);
    add(0, 8'h0C, 0, 8'h04, 8'h00, 8'h00, 1, 8'h04, 8'h04);
    add(0, 8'h0C, 0, 8'h0C, 8'h08, 8'h00, 1, 8'h0C, 8'h0C);
    add(0, 8'h1C, 0, 8'h0C, 8'h00, 8'h00, 1, 8'h0C, 8'h0C);
    add(0, 8'h1C, 0, 8'h0C, 8'h00, 8'h00, 1, 8'h0C, 8'h0C);
    add(0, 8'h1C, 0, 8'h0C, 8'h00, 8'h00, 1, 8'h0C, 8'h0C);
    add(0, 8'h1C, 1, 8'h1C, 8'h10, 8'h00, 1, 8'h1C, 8'h10);
    add(0, 8'h1C, 1, 8'h1C, 8'h00, 8'h00, 0, 8'h1C, 8'h00);
    // Multi-bit rise and fall in one cycle.
    add(1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h0F, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h0F, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h0F, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    add(0, 8'h0F, 0, 8'h0F, 8'h0F, 8'h00, 1, 8'h0F, 8'h0F);
    add(0, 8'h0F, 1, 8'h0F, 8'h00, 8'h00, 0, 8'h0F, 8'h00);
    add(0, 8'hF0, 0, 8'h0F, 8'h00, 8'h00, 0, 8'h0F, 8'h00);
    add(0, 8'hF0, 0, 8'h0F, 8'h00, 8'h00, 0, 8'h0F, 8'h00);
    add(0, 8'hF0, 0, 8'h0F, 8'h00, 8'h00, 0, 8'h0F, 8'h00);
    add(0, 8'hF0, 0, 8'hF0, 8'hF0, 8'h0F, 1, 8'hF0, 8'hFF);
    add(0, 8'hF0, 0, 8'hF0, 8'h00, 8'h00, 1, 8'hF0, 8'hFF);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].sync, vecs[i].ack);
      chk_all($sformatf("vec%0d", i), vecs[i].stable, vecs[i].rise, vecs[i].fall,
              vecs[i].valid, vecs[i].data, vecs[i].changed);
    end

    // Bounce on bit1: 1,1,1,0,1,1,1,1 -> accepted only at sample 8.
    begin
      logic [7:0] pat;
      pat = 8'b1111_0111;
      step(1, 8'h00, 0);
      for (int k = 0; k < 8; k++) begin
        step(0, {6'd0, pat[k], 1'b0}, 0);
        chk($sformatf("bounce.stable%0d", k + 1), STABLE, (k == 7) ? 8'h02 : 8'h00);
        chk($sformatf("bounce.rise%0d", k + 1), RISE, (k == 7) ? 8'h02 : 8'h00);
      end
    end

    // Reset mid-count discards the three partial samples.
    step(1, 8'h00, 0);
    for (int k = 0; k < 3; k++) step(0, 8'hFF, 0);
    chk("midrst.pre", STABLE, 8'h00);
    step(1, 8'hFF, 0);
    chk("midrst.rst_stable", STABLE, 8'h00);
    chk("midrst.rst_rise", RISE, 8'h00);
    chk("midrst.rst_valid", {7'd0, EVT_VALID}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step(0, 8'hFF, 0);
      chk($sformatf("midrst.stable%0d", k + 1), STABLE, (k == 3) ? 8'hFF : 8'h00);
      chk($sformatf("midrst.rise%0d", k + 1), RISE, (k == 3) ? 8'hFF : 8'h00);
    end

    // Randomized run against the window model.
    step(1, 8'h00, 0);
    model_edge(1, 8'h00, 0);
    begin
      logic [W-1:0] s;
      logic [W-1:0] m;
      logic r, a;
      s = '0;
      for (int n = 0; n < 2000; n++) begin
        m = '0;
        for (int b = 0; b < W; b++) m[b] = ($urandom_range(0, 9) == 0);
        s = s ^ m;
        r = ($urandom_range(0, 199) == 0);
        a = ($urandom_range(0, 3) == 0);
        step(r, s, a);
        model_edge(r, s, a);
        chk_all($sformatf("rnd%0d", n), m_stable, m_rise, m_fall, m_valid, m_data, m_changed);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_debounce_event.md
Name: sw_debounce_event

Overview:
- Consumer end of the switch-input path. Takes the already-synchronized switch levels (SYNC outputs of the 2-flop synchronizer bank) and filters out contact bounce.
- Presents debounced levels, single-cycle rise/fall pulses, and a change-event record with a valid/ack handshake.
- Downstream logic (VGA mode/colour select, control FSMs) sees only clean, debounced switch changes.

Parameters:
- WIDTH, 8, number of switch channels.
- DEBOUNCE_CYCLES, 250000, consecutive cycles of disagreement required to accept a new level (10 ms at 25 MHz). Legal range ≥1.
- CNT_W, 18, width of each per-channel counter. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous active-high reset.
- SYNC_IN  input  WIDTH  synchronized switch levels.
- STABLE  output  WIDTH  debounced switch levels.
- RISE  output  WIDTH  one-cycle pulse per bit on debounced 0→1.
- FALL  output  WIDTH  one-cycle pulse per bit on debounced 1→0.
- EVT_VALID  output  1  change event pending.
- EVT_DATA  output  WIDTH  STABLE value at most recent change.
- EVT_CHANGED  output  WIDTH  bits that changed since last accepted event.
- EVT_ACK  input  1  consumer accepts pending event.

Behaviour:
- Reset: one clock, synchronous, active-high. RST=1 at a rising edge drives STABLE, RISE, FALL, EVT_VALID, EVT_DATA, EVT_CHANGED and all counters to 0. Reset mid-count discards partial counts.
- Per-channel filter (independent per bit i), evaluated each edge with RST=0:
  - SYNC_IN[i]==STABLE[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: STABLE[i]<=SYNC_IN[i], cnt[i]<=0, flip[i]=1.
  - Else cnt[i]<=cnt[i]+1.
- Net effect: STABLE[i] updates at the DEBOUNCE_CYCLES-th consecutive sampling edge where SYNC_IN[i]!=STABLE[i].
- Any single matching sample restarts the count from 0.
- DEBOUNCE_CYCLES=1: STABLE follows SYNC_IN with 1-cycle latency.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
- RISE/FALL: registered, asserted exactly in the cycle STABLE first shows the new value.
  - RISE[i]=flip[i]&new STABLE[i]; FALL[i]=flip[i]&~new STABLE[i].
  - High for exactly one cycle. Multiple bits may pulse in the same cycle.
- Event register, with F = flip vector at this edge:
  - EVT_VALID=0 and F!=0: EVT_VALID<=1, EVT_DATA<=new STABLE, EVT_CHANGED<=F.
  - EVT_VALID=1, EVT_ACK=0, F!=0 (coalesce): EVT_DATA<=new STABLE, EVT_CHANGED<=EVT_CHANGED|F, EVT_VALID stays 1.
  - EVT_VALID=1, EVT_ACK=1, F==0: EVT_VALID<=0, EVT_CHANGED<=0. EVT_DATA holds.
  - EVT_VALID=1, EVT_ACK=1, F!=0: old event retired, new one loaded. EVT_VALID stays 1, EVT_CHANGED<=F (not OR'd), EVT_DATA<=new STABLE.
  - EVT_ACK while EVT_VALID=0: ignored.
- A bit that toggles twice before ack remains set in EVT_CHANGED. EVT_DATA shows the final level.
- No event is lost: every flip is reflected in either the retired or the pending EVT_CHANGED.
- Power-up with a switch held at 1: after reset, accepted after DEBOUNCE_CYCLES edges → RISE pulse and event. This is intended.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, WIDTH=8):
- Reset then SYNC_IN=8'h01 held → STABLE[0]=1 and RISE=8'h01 for one cycle appear 4 cycles after SYNC_IN applied; EVT_VALID=1, EVT_DATA=8'h01, EVT_CHANGED=8'h01.
- Bounce: SYNC_IN[1] pattern 1,1,1,0,1,1,1,1 → no change through 3rd 1; STABLE[1] rises only at the 4th consecutive 1 after the 0 (sample 8).
- Coalesce: bit2 accepted, no ack, then bit3 accepted → EVT_VALID stays 1, EVT_CHANGED=8'h0C, EVT_DATA=8'h0C; EVT_ACK → EVT_VALID=0, EVT_CHANGED=8'h00 next cycle.
- Simultaneous ack and flip: EVT_ACK asserted on same edge bit4 flips → EVT_VALID=1, EVT_CHANGED=8'h10 (old bits dropped), EVT_DATA reflects bit4.
- Multi-bit plus fall: SYNC_IN 8'h0F→8'hF0 held → RISE=8'hF0 and FALL=8'h0F in the same single cycle; STABLE=8'hF0.
- Reset mid-count: SYNC_IN=8'hFF for 3 cycles, RST pulse, SYNC_IN held → STABLE=0 until 4 further edges, then 8'hFF; no pulses during reset.
